pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Generates stall and flush controls for the F/D, D/E and E/M pipeline registers.
- Generates E-stage operand forwarding selects.
- Freezes the pipe while data memory is not ready, and runs a watchdog on that freeze.
- Keeps saturating stall/flush performance counters.
- Sits beside the decode and execute stages; consumes register addresses and control bits already present in the pipeline registers.

Parameters:
CNT_W, 16, width of each performance counter (saturating)
MAX_HOLD, 64, max consecutive ext-hold cycles before timeout error; legal range 2..2^16-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
Rs1D  in  5  rs1 field of instruction in D (InstrD[19:15])
Rs2D  in  5  rs2 field of instruction in D (InstrD[24:20])
Rs1E  in  5  rs1 address held in D/E register
Rs2E  in  5  rs2 address held in D/E register
RdE  in  5  destination in E
RegWriteE  in  1  E instruction writes rd
ResultSrcE  in  1  1 = E instruction is a load
RdM  in  5  destination in M
RegWriteM  in  1  M instruction writes rd
RdW  in  5  destination in W
RegWriteW  in  1  W instruction writes rd
PCSrcE  in  1  branch/jump taken, resolved in E
mem_stall_req  in  1  data memory not ready; freeze pipeline
clr_cnt  in  1  synchronous clear of performance counters
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register to bubble
FlushE  out  1  clear D/E register to bubble
ForwardAE  out  2  operand A select: 00 = regfile, 10 = M result, 01 = W result
ForwardBE  out  2  operand B select, same encoding
timeout_err  out  1  sticky watchdog error
stall_cycles  out  CNT_W  cycles with StallD=1
flush_events  out  CNT_W  taken-branch flushes applied

Behaviour:
- FSM states: RUN, HOLD, ERR. On reset: state RUN, hold counter 0, all outputs 0, counters 0.
- Forwarding (combinational, every state):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00. M has priority over W. ForwardBE uses the same rule on Rs2E.
- lduse = ResultSrcE && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- RUN, mem_stall_req=0 (combinational outputs):
  - PCSrcE=1: FlushD=1, FlushE=1, no stalls. Flush beats lduse, because the D instruction is wrong-path.
  - else if lduse: StallF=1, StallD=1, FlushE=1 (one bubble).
  - else all stall/flush outputs 0.
- RUN, mem_stall_req=1:
  - StallF/D/E/M=1, FlushD=FlushE=0. Any pending PCSrcE flush is deferred; PCSrcE stays stable because E is frozen.
  - Next state HOLD, hold counter set to 1.
- HOLD:
  - Same outputs as RUN with mem_stall_req=1; the hold counter increments each cycle.
  - mem_stall_req=0: return to RUN. That cycle's outputs are the RUN rules, so a deferred flush or lduse applies immediately.
  - If the hold counter reaches MAX_HOLD and mem_stall_req is still 1: go to ERR and set timeout_err.
- ERR:
  - StallF/D/E/M=1, flushes 0, forwards still computed.
  - Leaves ERR only on reset; timeout_err stays 1 until reset.
- stall_cycles: +1 on every clock edge where StallD=1 (all causes, including ERR).
- flush_events: +1 on each cycle where FlushD=1 due to PCSrcE.
- Both counters saturate at 2^CNT_W-1, no wrap. clr_cnt=1 zeroes both and beats any increment in that cycle.
- Asynchronous reset mid-HOLD or in ERR: immediate return to RUN with everything cleared.
- x0 is never a hazard source.

Optional Feature:
HAZARD_FWD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - RAW stall condition: Rs1D or Rs2D (nonzero) equals RdE&&RegWriteE, RdM&&RegWriteM, or RdW&&RegWriteW.
  - Response to that condition: StallF=StallD=1, FlushE=1, replacing lduse.
  - Priorities are unchanged: the mem freeze dominates, and PCSrcE beats the RAW stall.

Test Plan:
1. Forwarding: RdM=5/RegWriteM=1 and RdW=5/RegWriteW=1, Rs1E=5 -> ForwardAE=10; drop RegWriteM -> 01; Rs2E=0 with RdM=0 -> ForwardBE=00.
2. Load-use: ResultSrcE=1, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cycles increments by 1.
3. Branch + lduse same cycle: PCSrcE=1 with lduse true -> FlushD=FlushE=1, StallF=StallD=0; flush_events=1.
4. Memory hold: mem_stall_req=1 for 5 cycles while PCSrcE=1 -> Stall F/D/E/M=1 and no flush for 5 cycles; on release, FlushD=FlushE=1 in the next cycle; flush_events=1, stall_cycles=5.
5. Watchdog: MAX_HOLD=4, mem_stall_req held high -> timeout_err=1 after the 4th hold cycle; stays set after the request drops; clears only on rst=0.
6. Counter saturation/clear: CNT_W=4, 20 load-use stalls -> stall_cycles=15; clr_cnt=1 together with a stall -> stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and forwarding control for a 5-stage RV32 pipeline
//   clk, rst (async, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW, RegWriteE/M/W, ResultSrcE : hazard sources
//   PCSrcE        : taken branch/jump resolved in E
//   mem_stall_req : data memory not ready, freezes the whole pipe
//   clr_cnt       : synchronous clear of the performance counters
//   StallF/D/E/M, FlushD/E, ForwardAE/BE : pipeline controls
//   timeout_err   : sticky watchdog error on an over-long memory freeze
//   stall_cycles, flush_events : saturating performance counters
//   HAZARD_FWD_EN : when defined, E-stage forwarding plus load-use stall;
//                   when undefined, no forwarding and any RAW dependence stalls D
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mem_stall_req,
  input  logic             clr_cnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, HOLD, ERR} state_t;
  localparam logic [15:0] MAXH = 16'(MAX_HOLD);
  state_t state_q, state_d;
  logic [15:0] hold_q, hold_d, holdn;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic hz, frz;
`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd(input logic [4:0] rs);
    return (RegWriteM && RdM != 5'd0 && RdM == rs) ? 2'b10 :
           (RegWriteW && RdW != 5'd0 && RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  assign ForwardAE = fwd(Rs1E);
  assign ForwardBE = fwd(Rs2E);
  assign hz = ResultSrcE && RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
`else
  function automatic logic hit(input logic [4:0] rs);
    return rs != 5'd0 && ((RegWriteE && RdE == rs) || (RegWriteM && RdM == rs) ||
                          (RegWriteW && RdW == rs));
  endfunction
  logic unused_nofwd;
  assign unused_nofwd = ^{ResultSrcE, Rs1E, Rs2E};
  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;
  assign hz = hit(Rs1D) || hit(Rs2D);
`endif
  // A memory freeze (or the error state) holds every stage and defers any flush;
  // a taken branch squashes the D instruction, so it overrides the data-hazard stall.
  always_comb begin
    frz = state_q == ERR || mem_stall_req;
    StallE = frz;
    StallM = frz;
    StallF = frz || (!PCSrcE && hz);
    StallD = StallF;
    FlushD = !frz && PCSrcE;
    FlushE = !frz && (PCSrcE || hz);
    holdn = hold_q + 16'd1;
    state_d = state_q == ERR ? ERR : !mem_stall_req ? RUN :
              (state_q == HOLD && holdn == MAXH) ? ERR : HOLD;
    hold_d = state_d != HOLD ? 16'd0 : state_q == RUN ? 16'd1 : holdn;
    timeout_d = state_d == ERR;
    stall_d = clr_cnt ? '0 : (StallD && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = clr_cnt ? '0 : (FlushD && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of pipeline_hazard_ctrl (default and small-parameter instances)
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_stall_req, clr_cnt;
  logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_to;
  logic [1:0] a_fa, a_fb;
  logic [15:0] a_sc, a_fc;
  logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_to;
  logic [1:0] b_fa, b_fb;
  logic [3:0] b_sc, b_fc;
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM),
    .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .mem_stall_req(mem_stall_req), .clr_cnt(clr_cnt),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm), .FlushD(a_fd), .FlushE(a_fe),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .timeout_err(a_to), .stall_cycles(a_sc),
    .flush_events(a_fc));
  pipeline_hazard_ctrl #(.CNT_W(4), .MAX_HOLD(4)) u_b (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdM(RdM),
    .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .mem_stall_req(mem_stall_req), .clr_cnt(clr_cnt),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm), .FlushD(b_fd), .FlushE(b_fe),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .timeout_err(b_to), .stall_cycles(b_sc),
    .flush_events(b_fc));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, ResultSrcE, RegWriteM, RegWriteW, PCSrcE, mem_stall_req, clr_cnt} = '0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask
  task automatic set_lduse();
    ResultSrcE = 1'b1;
    RegWriteE = 1'b1;
    RdE = 5'd7;
    Rs2D = 5'd7;
  endtask
  initial begin
    rst = 1'b0;
    clear_in();
    #12;
    chk("rst_stallD", a_sd, 0);
    chk("rst_flushE", a_fe, 0);
    chk("rst_fwdA", a_fa, 0);
    chk("rst_timeout", a_to, 0);
    chk("rst_stall_cnt", a_sc, 0);
    chk("rst_flush_cnt", a_fc, 0);
    rst = 1'b1;
    cyc();
    // forwarding, priority M over W, x0 never forwarded
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
    #1;
    chk("fwdA_M", a_fa, FWD ? 2'b10 : 2'b00);
    chk("fwd_no_stall", a_sd, 0);
    RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", a_fa, FWD ? 2'b01 : 2'b00);
    RegWriteM = 1'b1; RdM = 5'd0; Rs2E = 5'd0;
    #1;
    chk("fwdB_x0", a_fb, 2'b00);
    RdM = 5'd5; Rs2E = 5'd5;
    #1;
    chk("fwdB_M", a_fb, FWD ? 2'b10 : 2'b00);
    clear_in();
    // RAW on an M-stage writer: stall only without forwarding
    Rs1D = 5'd9; RdM = 5'd9; RegWriteM = 1'b1;
    #1;
    chk("raw_stallD", a_sd, !FWD);
    chk("raw_flushE", a_fe, !FWD);
    clear_in();
    cyc();
    // load-use: one bubble
    do_reset();
    set_lduse();
    #1;
    chk("lu_stallF", a_sf, 1);
    chk("lu_stallD", a_sd, 1);
    chk("lu_flushE", a_fe, 1);
    chk("lu_flushD", a_fd, 0);
    chk("lu_stallE", a_se, 0);
    cyc();
    clear_in();
    #1;
    chk("lu_one_cycle", a_sd, 0);
    chk("lu_stall_cnt", a_sc, 1);
    // branch beats load-use
    do_reset();
    set_lduse();
    PCSrcE = 1'b1;
    #1;
    chk("br_flushD", a_fd, 1);
    chk("br_flushE", a_fe, 1);
    chk("br_stallF", a_sf, 0);
    chk("br_stallD", a_sd, 0);
    cyc();
    clear_in();
    #1;
    chk("br_flush_cnt", a_fc, 1);
    chk("br_stall_cnt", a_sc, 0);
    // memory hold defers the flush for 5 cycles
    do_reset();
    PCSrcE = 1'b1;
    mem_stall_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_stallM", a_sm, 1);
      chk("hold_stallD", a_sd, 1);
      chk("hold_flushD", a_fd, 0);
      cyc();
    end
    mem_stall_req = 1'b0;
    #1;
    chk("rel_flushD", a_fd, 1);
    chk("rel_flushE", a_fe, 1);
    chk("rel_stallE", a_se, 0);
    chk("rel_stall_cnt", a_sc, 5);
    cyc();
    clear_in();
    #1;
    chk("rel_flush_cnt", a_fc, 1);
    chk("rel_no_timeout", a_to, 0);
    // watchdog with MAX_HOLD=4
    do_reset();
    mem_stall_req = 1'b1;
    repeat (3) cyc();
    chk("wd_before", b_to, 0);
    cyc();
    chk("wd_timeout", b_to, 1);
    mem_stall_req = 1'b0;
    #1;
    chk("wd_err_stallD", b_sd, 1);
    chk("wd_err_stallM", b_sm, 1);
    chk("wd_a_runs", a_sd, 0);
    cyc();
    chk("wd_sticky", b_to, 1);
    chk("wd_stall_cnt", b_sc, 5);
    rst = 1'b0;
    #1;
    chk("wd_rst_clear", b_to, 0);
    chk("wd_rst_stallD", b_sd, 0);
    rst = 1'b1;
    cyc();
    // saturation at CNT_W=4, then clear beats increment
    do_reset();
    set_lduse();
    repeat (20) cyc();
    chk("sat_b", b_sc, 15);
    chk("sat_a", a_sc, 20);
    clr_cnt = 1'b1;
    cyc();
    chk("clr_b", b_sc, 0);
    chk("clr_a", a_sc, 0);
    clr_cnt = 1'b0;
    cyc();
    chk("after_clr_b", b_sc, 1);
    clear_in();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
